// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int BIT_CNT_W = 3;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    PTR_ACK  = 4'd4,
    WR_DATA  = 4'd5,
    WR_ACK   = 4'd6,
    RD_DATA  = 4'd7,
    RD_ACK   = 4'd8,
    IGNORE   = 4'd9
  } state_e;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// SCL/SDA synchronizers, SCL edge flags and START/STOP detection.
module i2c_bus_cond_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Shift chains and one-cycle history of the filtered lines.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Reset to the idle-bus level so leaving reset creates no false edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SCL edge never looks like START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a DEPTH x 8 register file: pointer byte, then sequential
// writes or reads with auto-increment.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h22,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe_o,
  output logic                     busy_o,
  output logic                     wr_stb_o,
  output logic [$clog2(DEPTH)-1:0] wr_idx_o,
  output logic [7:0]               wr_data_o,
  output logic                     rd_stb_o
);

  localparam int IW = $clog2(DEPTH);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_cond_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 phase_q, phase_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 wr_stb_q, wr_stb_d;
  logic [IW-1:0]        wr_idx_q, wr_idx_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 rd_stb_q, rd_stb_d;
  logic [7:0]           regs_q [DEPTH];
  logic [7:0]           regs_d [DEPTH];
  logic [7:0]           rx_byte;
  logic [7:0]           rd_byte;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];

  // Next-state and output logic; ACK states use phase_q to tell the
  // ACK-drive falling edge (0) from the end-of-ninth-clock falling edge (1).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    rd_stb_d  = 1'b0;
    regs_d    = regs_q;

    if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd7;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
                phase_d = 1'b0;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end

        PTR, WR_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              phase_d = 1'b0;
              if (state_q == PTR) begin
                ptr_d   = rx_byte[IW-1:0];
                state_d = PTR_ACK;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_stb_d      = 1'b1;
                wr_idx_d      = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_q + IW'(1);
                state_d       = WR_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end

        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = ~ACK;
            end else if (state_q == ADDR_ACK && rw_q) begin
              state_d   = RD_DATA;
              shift_d   = rd_byte;
              rd_stb_d  = 1'b1;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 3'd7;
            end else begin
              state_d   = (state_q == ADDR_ACK) ? PTR : WR_DATA;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd7;
            end
          end else if (scl_rise) begin
            phase_d = 1'b1;
          end else begin
            phase_d = phase_q;
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) begin
              state_d = RD_ACK;
              phase_d = 1'b0;
              ptr_d   = ptr_q + IW'(1);
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end

        RD_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b0;
            end else begin
              state_d   = RD_DATA;
              shift_d   = rd_byte;
              rd_stb_d  = 1'b1;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 3'd7;
            end
          end else if (scl_rise) begin
            if (sda_s == NACK) begin
              state_d = IGNORE;
            end else begin
              phase_d = 1'b1;
            end
          end else begin
            phase_d = phase_q;
          end
        end

        IDLE, IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and register file; async reset releases SDA immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd7;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      phase_q   <= 1'b0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= 8'h00;
      rd_stb_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      rd_stb_q  <= rd_stb_d;
      regs_q    <= regs_d;
    end
  end

  assign sda_oe_o  = sda_oe_q;
  assign busy_o    = busy_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_idx_o  = wr_idx_q;
  assign wr_data_o = wr_data_q;
  assign rd_stb_o  = rd_stb_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: a bit-banged I2C master drives the target over a wired-AND SDA.
module tb_i2c_target_regfile;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe_o;
  logic       busy_o;
  logic       wr_stb_o;
  logic [3:0] wr_idx_o;
  logic [7:0] wr_data_o;
  logic       rd_stb_o;

  int checks   = 0;
  int failures = 0;

  int         wr_cnt   = 0;
  int         rd_cnt   = 0;
  int         oe_cnt   = 0;
  int         busy_cnt = 0;
  logic [3:0] log_idx  [8];
  logic [7:0] log_data [8];

  assign sda_bus = sda_m & ~sda_oe_o;

  always #5 clk = ~clk;

  i2c_target_regfile #(
    .TARGET_ADDR(7'h22),
    .DEPTH      (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe_o (sda_oe_o),
    .busy_o   (busy_o),
    .wr_stb_o (wr_stb_o),
    .wr_idx_o (wr_idx_o),
    .wr_data_o(wr_data_o),
    .rd_stb_o (rd_stb_o)
  );

  // Strobe log and activity counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_stb_o) begin
      log_idx[wr_cnt[2:0]]  <= wr_idx_o;
      log_data[wr_cnt[2:0]] <= wr_data_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_stb_o) rd_cnt <= rd_cnt + 1;
    if (sda_oe_o) oe_cnt <= oe_cnt + 1;
    if (busy_o) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic qtr();
    repeat (10) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b0; qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b1; qtr();
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;    qtr();
    scl_m = 1'b1; qtr();
    s = sda_bus;  qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(d[i], dummy);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    send_bit(mack, dummy);
  endtask

  initial begin
    logic       a;
    logic [7:0] rd;
    int         wr0, rd0, oe0, busy0;

    rst_i = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_wr_stb", 32'(wr_stb_o), 32'h0);
    check("rst_rd_stb", 32'(rd_stb_o), 32'h0);
    check("rst_wr_idx", 32'(wr_idx_o), 32'h0);
    check("rst_wr_data", 32'(wr_data_o), 32'h0);
    rst_i = 1'b0;
    qtr();

    // Write ptr 3: A5, 5A
    bus_start();
    write_byte(8'h44, a); check("t1_addr_ack", 32'(a), 32'h0);
    check("t1_busy", 32'(busy_o), 32'h1);
    write_byte(8'h03, a); check("t1_ptr_ack", 32'(a), 32'h0);
    write_byte(8'hA5, a); check("t1_d0_ack", 32'(a), 32'h0);
    write_byte(8'h5A, a); check("t1_d1_ack", 32'(a), 32'h0);
    bus_stop();
    qtr();
    check("t1_busy_after_stop", 32'(busy_o), 32'h0);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd2);
    check("t1_idx0", 32'(log_idx[0]), 32'h3);
    check("t1_data0", 32'(log_data[0]), 32'hA5);
    check("t1_idx1", 32'(log_idx[1]), 32'h4);
    check("t1_data1", 32'(log_data[1]), 32'h5A);

    // Pointer write, repeated START, read two bytes
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus_start();
    write_byte(8'h44, a); check("t2_addr_ack", 32'(a), 32'h0);
    write_byte(8'h03, a); check("t2_ptr_ack", 32'(a), 32'h0);
    bus_start();
    write_byte(8'h45, a); check("t2_raddr_ack", 32'(a), 32'h0);
    read_byte(1'b0, rd); check("t2_rd0", 32'(rd), 32'hA5);
    read_byte(1'b1, rd); check("t2_rd1", 32'(rd), 32'h5A);
    check("t2_sda_released", 32'(sda_oe_o), 32'h0);
    bus_stop();
    qtr();
    check("t2_rd_cnt", 32'(rd_cnt - rd0), 32'd2);
    check("t2_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("t2_busy_after_stop", 32'(busy_o), 32'h0);

    // Foreign address 0x28
    wr0 = wr_cnt; oe0 = oe_cnt; busy0 = busy_cnt; rd0 = rd_cnt;
    bus_start();
    write_byte(8'h50, a); check("t3_addr_nack", 32'(a), 32'h1);
    write_byte(8'h12, a); check("t3_d0_nack", 32'(a), 32'h1);
    write_byte(8'h34, a); check("t3_d1_nack", 32'(a), 32'h1);
    bus_stop();
    qtr();
    check("t3_oe_never", 32'(oe_cnt - oe0), 32'd0);
    check("t3_busy_never", 32'(busy_cnt - busy0), 32'd0);
    check("t3_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("t3_no_rd", 32'(rd_cnt - rd0), 32'd0);

    // Pointer wrap 15 -> 0
    bus_start();
    write_byte(8'h44, a); check("t4_addr_ack", 32'(a), 32'h0);
    write_byte(8'h0F, a); check("t4_ptr_ack", 32'(a), 32'h0);
    write_byte(8'h11, a); check("t4_d0_ack", 32'(a), 32'h0);
    write_byte(8'h22, a); check("t4_d1_ack", 32'(a), 32'h0);
    bus_stop();
    qtr();
    check("t4_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t4_idx0", 32'(log_idx[2]), 32'hF);
    check("t4_data0", 32'(log_data[2]), 32'h11);
    check("t4_idx1", 32'(log_idx[3]), 32'h0);
    check("t4_data1", 32'(log_data[3]), 32'h22);
    bus_start();
    write_byte(8'h44, a);
    write_byte(8'h0F, a);
    bus_start();
    write_byte(8'h45, a); check("t4_raddr_ack", 32'(a), 32'h0);
    read_byte(1'b0, rd); check("t4_reg15", 32'(rd), 32'h11);
    read_byte(1'b1, rd); check("t4_reg0", 32'(rd), 32'h22);
    bus_stop();
    qtr();

    // STOP after 4 data bits, then a clean write to ptr 0
    wr0 = wr_cnt;
    bus_start();
    write_byte(8'h44, a);
    write_byte(8'h05, a); check("t5_ptr_ack", 32'(a), 32'h0);
    send_bit(1'b1, a); send_bit(1'b0, a); send_bit(1'b1, a); send_bit(1'b0, a);
    bus_stop();
    qtr();
    check("t5_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("t5_busy", 32'(busy_o), 32'h0);
    check("t5_oe", 32'(sda_oe_o), 32'h0);
    bus_start();
    write_byte(8'h44, a); check("t5_addr_ack", 32'(a), 32'h0);
    write_byte(8'h00, a); check("t5_ptr0_ack", 32'(a), 32'h0);
    write_byte(8'h77, a); check("t5_d_ack", 32'(a), 32'h0);
    bus_stop();
    qtr();
    check("t5_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    check("t5_idx", 32'(log_idx[4]), 32'h0);
    check("t5_data", 32'(log_data[4]), 32'h77);

    // Reset while the target drives the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] addr_w;
      addr_w = 8'h44;
      send_bit(addr_w[i], a);
    end
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    check("t6_ack_driven", 32'(sda_oe_o), 32'h1);
    rst_i = 1'b1;
    #1;
    check("t6_oe_released", 32'(sda_oe_o), 32'h0);
    check("t6_busy", 32'(busy_o), 32'h0);
    qtr();
    scl_m = 1'b0; qtr();
    rst_i = 1'b0; qtr();
    bus_stop();
    qtr();
    bus_start();
    write_byte(8'h44, a); check("t6_addr_ack", 32'(a), 32'h0);
    write_byte(8'h03, a);
    bus_start();
    write_byte(8'h45, a);
    read_byte(1'b0, rd); check("t6_reg3_cleared", 32'(rd), 32'h00);
    read_byte(1'b1, rd); check("t6_reg4_cleared", 32'(rd), 32'h00);
    bus_stop();
    qtr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
